qos_ctrl: RTL
=============

QOS_CTRL -- requirements
Module: qos_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, 200, CLK cycles per hold tick; legal range 2..256.
REQ-002 SHALL have parameter HOLD_TICKS, 20, hold ticks after an I/O QoS trigger; legal range 1..255.
REQ-003 SHALL have parameter SND_HOLD_TICKS, 255, hold ticks after a sound-buffer write trigger; legal range 1..255.
REQ-004 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nRES  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port BACT  input  1  CPU bus cycle active, already synchronous to CLK.
REQ-007 SHALL have port QoSCS  input  1  current address decodes to IACK/VIA/IWM/SCC/SCSI.
REQ-008 SHALL have port SndQoSCS  input  1  current access is a write to the sound-buffer pages.
REQ-009 SHALL have port QoSEN  output  1  registered; high forces all cycles onto the I/O bus path and disables posted writes.
REQ-010 SHALL have port QoSBusy  output  1  registered; high in any state other than IDLE.

Function
REQ-011 SHALL register BACT into BACTr each cycle; trigger = BACT & !BACTr & (QoSCS | SndQoSCS), sampled only on the cycle-start edge.
REQ-012 SHALL define reload = SND_HOLD_TICKS when SndQoSCS is high, else HOLD_TICKS; when both are high, the larger value.
REQ-013 SHALL implement the four states IDLE, ARM, ACTIVE and RELEASE; QoSEN = 1 exactly in ACTIVE and RELEASE.
REQ-014 SHALL hold an 8-bit count register; on a trigger it SHALL load max(count, reload) and never shorten a running hold.
REQ-015 SHALL hold an 8-bit prescaler that increments every cycle in ACTIVE, wraps from PRESCALE-1 to 0, and produces tick on the wrap cycle.
REQ-016 SHALL clear the prescaler to 0 on every count load so that the first tick after a load is a full PRESCALE period.
REQ-017 IDLE: trigger -> ARM with count loaded; otherwise stay.
REQ-018 ARM: the next edge with BACT=0 -> ACTIVE, so QoSEN only rises between bus cycles; a trigger in ARM SHALL reload per REQ-014.
REQ-019 ACTIVE: a tick decrements count; tick with count=1 and no trigger -> RELEASE with count=0.
REQ-020 ACTIVE: trigger and tick on the same cycle -> the reload per REQ-014 wins and there is no decrement; the state stays ACTIVE.
REQ-021 RELEASE: the first edge with BACT=0 -> IDLE, so QoSEN only falls between bus cycles; a trigger in RELEASE -> ACTIVE with reload and QoSEN held at 1.
REQ-022 SHALL never change QoSEN on an edge where BACT=1 was sampled, except that QoSEN SHALL stay 1 on the RELEASE->ACTIVE retrigger.
REQ-023 Count SHALL never underflow; it SHALL decrement only when count>0.

Reset
REQ-024 nRES low SHALL immediately force state=IDLE, count=0, prescaler=0, BACTr=0, QoSEN=0 and QoSBusy=0.
REQ-025 Reset asserted mid-hold SHALL drop QoSEN asynchronously; the first BACT rise after release SHALL be treated as a fresh trigger candidate.

Structure
REQ-026 The state encoding enum and the 8-bit count width constant SHALL live in the shared package wse_pkg; parameters stay local.
REQ-027 The prescaler/tick generator SHALL be one sub-module qos_tick (inputs CLK, nRES, en, clr; output tick); everything else stays flat.

Verification (PRESCALE=4, HOLD_TICKS=3, SND_HOLD_TICKS=6)
REQ-028 Scenario 1: BACT rises with QoSCS=1 and falls 3 cycles later -> ARM, then ACTIVE and QoSEN=1 on the BACT=0 edge; QoSEN falls 12 CLK after ACTIVE entry with BACT low.
REQ-029 Scenario 2: SndQoSCS trigger at count=2 in ACTIVE -> count=6 and the prescaler is cleared; QoSEN lasts 24 further CLK.
REQ-030 Scenario 3: count reaches 0 while BACT=1 -> RELEASE, QoSEN stays 1 until the first BACT=0 edge, then IDLE.
REQ-031 Scenario 4: QoSCS trigger in RELEASE -> ACTIVE with count=3 and no QoSEN glitch.
REQ-032 Scenario 5: trigger coincident with tick at count=1 -> count=3 and the state stays ACTIVE.
REQ-033 Scenario 6: nRES pulsed low mid-ACTIVE, asynchronous to CLK -> QoSEN=0 with no clock edge; the next QoSCS cycle start re-arms normally.

Source files
------------

// File: rtl/wse_pkg.sv
// Shared definitions for the I/O QoS hold controller.
//   CNT_W       : width of the hold count and prescaler registers
//   qos_state_e : controller state encoding
package wse_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_ACTIVE,
      ST_RELEASE
   } qos_state_e;

endpackage

// File: rtl/qos_tick.sv
// Hold-tick prescaler: counts CLK cycles while enabled and pulses tick on the
// cycle it wraps from PRESCALE-1 back to 0.
//   CLK  : clock
//   nRES : asynchronous active-low reset
//   en   : count enable (controller is holding)
//   clr  : synchronous clear, restarts a full PRESCALE period
//   tick : high on the wrap cycle
module qos_tick
   import wse_pkg::*;
#(
   parameter int unsigned PRESCALE = 200
) (
   input  logic CLK,
   input  logic nRES,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] pre_q, pre_d;

   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = (pre_q == LAST) ? '0 : pre_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign tick = en & (pre_q == LAST);

endmodule

// File: rtl/qos_ctrl.sv
// I/O QoS hold controller. A bus-cycle start that decodes to a slow I/O device
// or a sound-buffer write arms a hold; QoSEN is raised between bus cycles and
// kept for a number of prescaled ticks, then dropped between bus cycles.
//   CLK      : clock
//   nRES     : asynchronous active-low reset
//   BACT     : CPU bus cycle active (synchronous)
//   QoSCS    : access decodes to IACK/VIA/IWM/SCC/SCSI
//   SndQoSCS : access is a sound-buffer write
//   QoSEN    : registered, forces I/O bus path / disables posted writes
//   QoSBusy  : registered, controller not idle
module qos_ctrl
   import wse_pkg::*;
#(
   parameter int unsigned PRESCALE       = 200,
   parameter int unsigned HOLD_TICKS     = 20,
   parameter int unsigned SND_HOLD_TICKS = 255
) (
   input  logic CLK,
   input  logic nRES,
   input  logic BACT,
   input  logic QoSCS,
   input  logic SndQoSCS,
   output logic QoSEN,
   output logic QoSBusy
);

   localparam logic [CNT_W-1:0] HOLD_R = CNT_W'(HOLD_TICKS);
   localparam logic [CNT_W-1:0] SND_R  = CNT_W'(SND_HOLD_TICKS);
   localparam logic [CNT_W-1:0] BOTH_R = (SND_R > HOLD_R) ? SND_R : HOLD_R;

   qos_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             bactr_q;
   logic             qosen_q, qosen_d;
   logic             busy_q, busy_d;

   logic             trigger;
   logic             load;
   logic             tick;
   logic [CNT_W-1:0] reload;
   logic [CNT_W-1:0] load_val;

   assign trigger  = BACT & ~bactr_q & (QoSCS | SndQoSCS);
   assign reload   = SndQoSCS ? (QoSCS ? BOTH_R : SND_R) : HOLD_R;
   // A trigger may only extend a running hold, never shorten it.
   assign load_val = (count_q > reload) ? count_q : reload;

   qos_tick #(
      .PRESCALE(PRESCALE)
   ) u_tick (
      .CLK  (CLK),
      .nRES (nRES),
      .en   (state_q == ST_ACTIVE),
      .clr  (load),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      load    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               state_d = ST_ARM;
               load    = 1'b1;
            end
         end
         ST_ARM: begin
            if (trigger) begin
               load = 1'b1;
            end else if (!BACT) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            // A reload on the tick cycle suppresses that tick's decrement.
            if (trigger) begin
               load = 1'b1;
            end else if (tick) begin
               if (count_q == CNT_W'(1)) begin
                  state_d = ST_RELEASE;
                  count_d = '0;
               end else if (count_q != '0) begin
                  count_d = count_q - CNT_W'(1);
               end
            end
         end
         ST_RELEASE: begin
            if (trigger) begin
               state_d = ST_ACTIVE;
               load    = 1'b1;
            end else if (!BACT) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         count_d = load_val;
      end
      qosen_d = (state_d == ST_ACTIVE) || (state_d == ST_RELEASE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         bactr_q <= 1'b0;
         qosen_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bactr_q <= BACT;
         qosen_q <= qosen_d;
         busy_q  <= busy_d;
      end
   end

   assign QoSEN   = qosen_q;
   assign QoSBusy = busy_q;

endmodule
